// File: rtl/ser_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package ser_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/ser_sub8.sv
// Bit-serial subtractor: A - B computed LSB-first, one bit per enabled clock.
// Optional signed-overflow output enabled by defining SER_SUB_OVF_EN.
module ser_sub8
    import ser_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SER_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               borrow_q, borrow_d;
`ifdef SER_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic               bit_d;
    logic               bit_bout;

    full_sub_bit u_full_sub_bit (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        borrow_d = borrow_q;
`ifdef SER_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_d  = a;
                        b_sr_d  = b;
                        br_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = SHIFT;
`ifdef SER_SUB_OVF_EN
                        a_msb_d = a[WIDTH-1];
                        b_msb_d = b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    // Result bit enters at the MSB so diff is aligned after WIDTH shifts
                    diff_d = {bit_d, diff_q[WIDTH-1:1]};
                    a_sr_d = a_sr_q >> 1;
                    b_sr_d = b_sr_q >> 1;
                    br_d   = bit_bout;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        borrow_d = bit_bout;
`ifdef SER_SUB_OVF_EN
                        ovf_d    = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SER_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
`ifdef SER_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        busy   = (state_q == SHIFT);
        done   = (state_q == DONE);
        diff   = diff_q;
        borrow = borrow_q;
`ifdef SER_SUB_OVF_EN
        ovf    = ovf_q;
`endif
    end

endmodule

// File: tb/tb_ser_sub8.sv
// Scoreboard bench for ser_sub8; checks ovf too when SER_SUB_OVF_EN is defined.
module tb_ser_sub8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
`ifdef SER_SUB_OVF_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    typedef struct packed {
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];

    ser_sub8 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SER_SUB_OVF_EN
        .ovf    (ovf),
`endif
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        e.diff   = av - bv;
        e.borrow = (av < bv);
        e.ovf    = (av[7] != bv[7]) && (e.diff[7] != av[7]);
        return e;
    endfunction

    // Output side of the scoreboard: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, e.diff});
                chk("borrow", {31'd0, borrow}, {31'd0, e.borrow});
`ifdef SER_SUB_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Drive one start pulse; returns after the accepting edge
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input bit expect_result);
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        if (expect_result) sb_q.push_back(model(av, bv));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
    endtask

    // Counts cycles after acceptance until done; optional ena gap and mid-SHIFT restart
    task automatic wait_done(input int gap_at, input int gap_len, input int restart_at,
                             output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            if (lat == gap_at) ena = 1'b0;
            if (lat == gap_at + gap_len) ena = 1'b1;
            if (lat == restart_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        ena = 1'b1;
        start = 1'b0;
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic basic_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
        int lat, bc;
        issue(av, bv, 1'b1);
        wait_done(-1, 0, -1, lat, bc);
        chk({tag, "_lat"}, lat, 9);
        chk({tag, "_busy"}, bc, 8);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {31'd0, busy | done}, 32'd0);
    endtask

    initial begin
        int lat, bc, dn;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = '0; b = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_diff", {24'd0, diff}, 32'd0);
        chk("idle_borrow", {31'd0, borrow}, 32'd0);

        basic_op(8'h0F, 8'h01, "op_0f_01");
        basic_op(8'h01, 8'h02, "op_01_02");
        basic_op(8'hAA, 8'h55, "op_aa_55");
        basic_op(8'h00, 8'h00, "op_00_00");
        basic_op(8'h7F, 8'h80, "op_7f_80");

        // start re-asserted mid-SHIFT must be ignored
        dn = n_done;
        issue(8'h10, 8'h03, 1'b1);
        wait_done(-1, 0, 3, lat, bc);
        chk("restart_lat", lat, 9);
        repeat (12) @(posedge clk);
        #1;
        chk("restart_single_done", n_done - dn, 1);

        // ena low for 5 cycles during SHIFT delays done by exactly 5
        issue(8'h80, 8'h01, 1'b1);
        wait_done(3, 5, -1, lat, bc);
        chk("ena_gap_lat", lat, 14);
        chk("ena_gap_busy", bc, 13);
        @(posedge clk); #1;

        // start held high: second accept one IDLE cycle after DONE
        issue(8'h33, 8'h11, 1'b1);
        sb_q.push_back(model(8'h44, 8'h45));
        wait_done(-1, 0, -1, lat, bc);
        chk("b2b_lat1", lat, 9);
        a = 8'h44; b = 8'h45; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_gap_idle", {31'd0, busy | done}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy2", {31'd0, busy}, 32'd1);
        wait_done(-1, 0, -1, lat, bc);
        chk("b2b_lat2", lat, 9);
        @(posedge clk); #1;

        // reset mid-operation aborts without a done pulse
        dn = n_done;
        issue(8'hC3, 8'h5A, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_borrow", {31'd0, borrow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_done", n_done - dn, 0);
        basic_op(8'h05, 8'h03, "op_05_03");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ser_sub8.md
Name: ser_sub8

Overview:
- Bit-serial subtractor: the inverse-operation companion to the team's 8-bit parallel adder project.
- Accepts two WIDTH-bit operands on a start strobe and computes A − B LSB-first, one bit per enabled clock.
- Returns the difference plus a borrow-out with a one-cycle done pulse.
- Sits behind the ui_in/uio_in operand pins inside a tt_um_* top; trades area for latency.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)
CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; when low all state is frozen
start  input  1  request; sampled only in IDLE with ena=1
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse in DONE state
diff  output  WIDTH  A − B mod 2^WIDTH, valid from done until next accepted start
borrow  output  1  1 when A < B unsigned, valid with diff

Behaviour:
- Clock/reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, diff=0, borrow=0, counter=0, operand shift regs=0.
- FSM states: IDLE, SHIFT, DONE. All transitions require ena=1; with ena=0 every register holds, including done.
- IDLE: start=1 → latch a, b into shift regs, borrow-chain reg br=0, cnt=0, go to SHIFT. start=0 → stay.
- SHIFT, per enabled edge:
  - d = a_sr[0] ^ b_sr[0] ^ br
  - br' = (~a_sr[0] & b_sr[0]) | (~(a_sr[0]^b_sr[0]) & br)
  - d shifts into diff at the MSB (diff >> 1); a_sr and b_sr shift right; cnt++.
  - When cnt==WIDTH-1 on that edge → go to DONE. borrow output updates from br' on that same final edge.
- DONE: done=1 for exactly one enabled cycle, then IDLE. diff/borrow are held until the next accepted start.
- Latency: start accepted at edge k → busy high in cycles k+1..k+WIDTH → done high in the cycle after edge k+WIDTH. Nominal 9 cycles for WIDTH=8.
- During SHIFT, diff shows partial results; consumers use done.
- start while in SHIFT or DONE is ignored; no queuing.
- start held high continuously gives back-to-back operations with one IDLE cycle between.
- Operand inputs may change freely after acceptance.
- rst_n asserted mid-operation: immediate abort to reset values; no done pulse.
- Arithmetic: result is modulo 2^WIDTH. borrow equals the final chain borrow; no sign interpretation unless the optional feature is enabled.

Optional Feature:
- Macro SER_SUB_OVF_EN.
- Defined: extra output ovf (1 bit, reset 0) = signed two's-complement overflow, computed as (a_msb != b_msb) && (diff_msb != a_msb). Requires a latched copy of the original operand MSBs. Updated on the same edge as borrow and held with diff.
- Undefined: port absent, no extra registers.

Decomposition:
- Package ser_sub_pkg:
  - state enum typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - DEFAULT_WIDTH=8 constant
- Sub-module full_sub_bit: combinational 1-bit full subtractor (a, b, bin → d, bout), instantiated once in the SHIFT datapath.
- FSM, counter and shift registers stay in ser_sub8.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release → busy=0, done=0, diff=0x00, borrow=0; no activity without start.
- a=0x0F, b=0x01, start 1 cycle → busy 8 cycles, done pulse on 9th cycle after accept; diff=0x0E, borrow=0.
- a=0x01, b=0x02 → diff=0xFF, borrow=1. Then a=0xAA, b=0x55 → diff=0x55, borrow=0. Then a=0x00, b=0x00 → diff=0x00, borrow=0.
- Start re-asserted mid-SHIFT with a=0xFF, b=0xFF during a 0x10−0x03 op → ignored; diff=0x0D, borrow=0, single done pulse.
- ena low for 5 cycles during SHIFT (a=0x80, b=0x01) → state and cnt frozen, done delayed by exactly 5 cycles; diff=0x7F, borrow=0; ovf=1 when SER_SUB_OVF_EN is defined.
- rst_n pulsed low after 4 SHIFT cycles → outputs return to reset values immediately, no done; a following 0x05−0x03 op gives diff=0x02.
